// File: rtl/morse_pkg.sv
// Shared definitions for the Morse player: symbol codes, code geometry,
// duration counter width and the player state encoding.
package morse_pkg;

  localparam int CODE_W    = 10;  // five 2-bit symbols, MSB first
  localparam int SYM_COUNT = 5;   // symbols held in one code word
  localparam int TIMER_W   = 26;  // duration down-counter width

  localparam logic [1:0] SYM_DOT  = 2'b10;
  localparam logic [1:0] SYM_DASH = 2'b11;
  localparam logic [1:0] SYM_END  = 2'b00;  // 01 is also treated as a terminator

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ON     = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/morse_player_if.sv
// Request/status bundle for the Morse player.
//   start     : request to play morseCode (honoured only while idle)
//   morseCode : five 2-bit symbols, MSB first
//   lampOut   : high while a dot or dash is sounding
//   busy      : high whenever the player is not idle
//   done      : one-cycle pulse when playback completes
// master = requester side, slave = player side.
interface morse_player_if;

  logic                        start;
  logic [morse_pkg::CODE_W-1:0] morseCode;
  logic                        lampOut;
  logic                        busy;
  logic                        done;

  modport master (output start, morseCode, input lampOut, busy, done);
  modport slave  (input start, morseCode, output lampOut, busy, done);

endinterface

// File: rtl/morse_unit_timer.sv
// Duration down-counter for the Morse player.
//   clk     : system clock
//   reset   : synchronous, active-low reset (clears the count)
//   load    : load value into the counter this cycle
//   value   : duration minus one
//   expired : high when the count has reached zero
// The counter holds at zero, so a phase loaded with (N-1) lasts N cycles.
module morse_unit_timer
  import morse_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/morse_player.sv
// Morse code lamp player.
//   clk   : system clock
//   reset : synchronous, active-low reset
//   abort : (only when MORSE_PLAYER_ABORT_EN is defined) drop the current
//           playback and return to idle with no done pulse
//   bus   : morse_player_if slave (start, morseCode in; lampOut, busy, done out)
// A latched code is played symbol by symbol: FETCH decodes the top symbol,
// ON sounds it, GAP separates it from the next, FINISH pulses done.
module morse_player
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12500000,
  parameter int DASH_UNITS  = 3,
  parameter int GAP_UNITS   = 1
) (
  input  logic           clk,
  input  logic           reset,
`ifdef MORSE_PLAYER_ABORT_EN
  input  logic           abort,
`endif
  morse_player_if.slave  bus
);

  localparam longint DASH_TOTAL = longint'(DASH_UNITS) * longint'(UNIT_CYCLES);
  localparam longint GAP_TOTAL  = longint'(GAP_UNITS) * longint'(UNIT_CYCLES);
  localparam longint TIMER_SPAN = longint'(1) << TIMER_W;

  // Every phase length must fit the 26-bit counter and be at least one cycle.
  if (UNIT_CYCLES < 1 || DASH_UNITS < 1 || GAP_UNITS < 1 ||
      DASH_TOTAL >= TIMER_SPAN || GAP_TOTAL >= TIMER_SPAN) begin : g_bad_params
    $error("morse_player: illegal UNIT_CYCLES/DASH_UNITS/GAP_UNITS");
  end

  localparam logic [TIMER_W-1:0] DOT_LOAD  = TIMER_W'(UNIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DASH_LOAD = TIMER_W'(DASH_TOTAL - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_TOTAL - 1);
  localparam logic [2:0]         LAST_SYM  = 3'(SYM_COUNT - 1);

  state_t              state, state_next;
  logic [CODE_W-1:0]   code_reg;
  logic [2:0]          sym_count;
  logic                latch_code, shift_code;
  logic                timer_load, timer_expired;
  logic [TIMER_W-1:0]  timer_value;

  morse_unit_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the code register and symbol count are cleared on reset so a
      // reset leaves no trace of an abandoned code.
      state     <= ST_IDLE;
      code_reg  <= '0;
      sym_count <= '0;
    end else begin
      state <= state_next;
      if (latch_code) begin
        code_reg  <= bus.morseCode;
        sym_count <= '0;
      end else if (shift_code) begin
        code_reg  <= {code_reg[CODE_W-3:0], 2'b00};
        sym_count <= sym_count + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // can leave one unassigned and infer a latch.
    state_next  = state;
    latch_code  = 1'b0;
    shift_code  = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          latch_code = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (code_reg[CODE_W-1:CODE_W-2] == SYM_DOT) begin
          timer_load  = 1'b1;
          timer_value = DOT_LOAD;
          state_next  = ST_ON;
        end else if (code_reg[CODE_W-1:CODE_W-2] == SYM_DASH) begin
          timer_load  = 1'b1;
          timer_value = DASH_LOAD;
          state_next  = ST_ON;
        end else begin
          state_next = ST_FINISH;
        end
      end
      ST_ON: begin
        if (timer_expired) begin
          timer_load  = 1'b1;
          timer_value = GAP_LOAD;
          state_next  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (timer_expired) begin
          shift_code = 1'b1;
          // sym_count still holds the pre-increment value here.
          state_next = (sym_count == LAST_SYM) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
`ifdef MORSE_PLAYER_ABORT_EN
    // Abort overrides every other transition outside IDLE.
    if (abort && state != ST_IDLE) begin
      state_next = ST_IDLE;
      latch_code = 1'b0;
      shift_code = 1'b0;
      timer_load = 1'b0;
    end
`endif
  end

  assign bus.lampOut = (state == ST_ON);
  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = (state == ST_FINISH);

endmodule

// File: tb/tb_morse_player.sv
// Self-checking bench for morse_player (UNIT_CYCLES=4, DASH_UNITS=3,
// GAP_UNITS=1). Expected lamp/busy/done timelines are derived from the
// symbol list of each code with plain cycle arithmetic.
module tb_morse_player;

  localparam int UNIT = 4;
  localparam int DASH = 3;
  localparam int GAPU = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
`ifdef MORSE_PLAYER_ABORT_EN
  logic abort = 1'b0;
`endif

  morse_player_if bus ();

  morse_player #(
    .UNIT_CYCLES (UNIT),
    .DASH_UNITS  (DASH),
    .GAP_UNITS   (GAPU)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef MORSE_PLAYER_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference timeline of one playback, cycle 0 = cycle start is presented.
  int lamp_lo [5];
  int lamp_hi [5];
  int n_lamps;
  int fin;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbols sound one after another: fetch (1) + sound + gap; a
  // terminator costs a fetch then finishes, five symbols finish directly.
  function automatic void build_model(input logic [9:0] code);
    int t;
    int dur;
    logic [1:0] sym;
    t       = 1;
    n_lamps = 0;
    fin     = -1;
    for (int i = 0; i < 5; i++) begin
      sym = code[9-2*i -: 2];
      if (sym[1] == 1'b0) begin
        fin = t + 1;
        break;
      end
      dur = (sym[0] == 1'b1) ? DASH * UNIT : UNIT;
      lamp_lo[n_lamps] = t + 1;
      lamp_hi[n_lamps] = t + dur;
      n_lamps++;
      t = t + 1 + dur + GAPU * UNIT;
    end
    if (fin < 0) fin = t;
  endfunction

  function automatic logic exp_lamp(input int c);
    for (int i = 0; i < n_lamps; i++)
      if (c >= lamp_lo[i] && c <= lamp_hi[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("idle_busy@%0d", i), 32'(bus.busy), 32'd0);
      check($sformatf("idle_lamp@%0d", i), 32'(bus.lampOut), 32'd0);
      check($sformatf("idle_done@%0d", i), 32'(bus.done), 32'd0);
      step();
    end
  endtask

  // Plays one code from the current cycle. repulse/chg/rst/abrt give the
  // cycle of an extra start pulse, a morseCode change, a reset or an abort
  // (-1 = none). After a reset/abort at cycle k all outputs must be low
  // from k+1; the task returns in the cycle after its last checked one.
  task automatic play(input string name, input logic [9:0] code, input int repulse,
                      input int chg, input logic [9:0] chg_code, input int rst, input int abrt);
    int  cut;
    int  last;
    logic el, e_lamp, e_busy, e_done;
    build_model(code);
    cut = -1;
    if (rst >= 0)  cut = rst;
    if (abrt >= 0) cut = abrt;
    last = (cut >= 0) ? cut + 1 : fin + 1;
    bus.morseCode = code;
    for (int c = 0; c <= last; c++) begin
      bus.start = (c == 0) || (c == repulse);
      if (c == chg) bus.morseCode = chg_code;
      reset = (c != rst);
`ifdef MORSE_PLAYER_ABORT_EN
      abort = (c == abrt);
`endif
      el     = (cut >= 0) && (c > cut);
      e_lamp = el ? 1'b0 : exp_lamp(c);
      e_busy = el ? 1'b0 : (c >= 1 && c <= fin);
      e_done = el ? 1'b0 : (c == fin);
      check($sformatf("%s_lamp@%0d", name, c), 32'(bus.lampOut), 32'(e_lamp));
      check($sformatf("%s_busy@%0d", name, c), 32'(bus.busy), 32'(e_busy));
      check($sformatf("%s_done@%0d", name, c), 32'(bus.done), 32'(e_done));
      step();
    end
    bus.start = 1'b0;
    reset     = 1'b1;
`ifdef MORSE_PLAYER_ABORT_EN
    abort     = 1'b0;
`endif
  endtask

  function automatic logic [9:0] rand_code();
    logic [9:0] code;
    int r;
    code = '0;
    for (int i = 0; i < 5; i++) begin
      r = int'($urandom_range(0, 9));
      code = code << 2;
      if (r < 4)      code[1:0] = 2'b10;
      else if (r < 8) code[1:0] = 2'b11;
      else            code[1:0] = 2'($urandom_range(0, 1));
    end
    return code;
  endfunction

  initial begin
    logic [9:0] code;
    int rep, chg, rst, abrt;

    bus.start     = 1'b0;
    bus.morseCode = '0;
    reset         = 1'b0;
    repeat (3) step();
    check("reset_lamp", 32'(bus.lampOut), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    step();

    // Directed reference playbacks.
    play("e",    10'b1000000000, -1, -1, 10'h000, -1, -1);
    idle(2);
    play("t",    10'b1100000000, -1, -1, 10'h000, -1, -1);
    idle(1);
    play("zero", 10'b1111111111, -1, -1, 10'h000, -1, -1);
    idle(1);
    play("empty", 10'b0000000000, -1, -1, 10'h000, -1, -1);
    idle(1);

    // Re-pulsed start and a changed morseCode must not disturb "e".
    play("e_ign", 10'b1000000000, 5, 3, 10'h3FF, -1, -1);
    idle(1);
    // Start during FINISH is ignored.
    play("t_fin", 10'b1100000000, 19, -1, 10'h000, -1, -1);
    idle(1);
    // Reset mid-playback, then start straight after reset releases.
    play("t_rst", 10'b1100000000, -1, -1, 10'h000, 3, -1);
    play("e_after_rst", 10'b1000000000, -1, -1, 10'h000, -1, -1);
    idle(1);

`ifdef MORSE_PLAYER_ABORT_EN
    play("zero_abort", 10'b1111111111, -1, -1, 10'h000, -1, 20);
    play("zero_replay", 10'b1111111111, -1, -1, 10'h000, -1, -1);
    idle(1);
`endif

    // Randomized playbacks with disturbances.
    for (int n = 0; n < 24; n++) begin
      code = rand_code();
      build_model(code);
      rep  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, fin)) : -1;
      chg  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, fin)) : -1;
      rst  = -1;
      abrt = -1;
      if ($urandom_range(0, 5) == 0) begin
        rst = int'($urandom_range(1, fin));
        rep = -1;
      end
`ifdef MORSE_PLAYER_ABORT_EN
      else if ($urandom_range(0, 5) == 0) begin
        abrt = int'($urandom_range(1, fin));
        rep  = -1;
      end
`endif
      play($sformatf("rnd%0d", n), code, rep, chg, 10'($urandom), rst, abrt);
      idle(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/morse_player.md
MORSE_PLAYER -- requirements
Module: morse_player

Interface
REQ-001 SHALL have parameter: UNIT_CYCLES, 12500000, clock cycles per Morse time unit (0.25 s at 50 MHz).
REQ-002 SHALL have parameter: DASH_UNITS, 3, dash length in units.
REQ-003 SHALL have parameter: GAP_UNITS, 1, inter-symbol gap length in units.
REQ-004 SHALL have port: clk  input  1  system clock; the block uses one clock.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: start  input  1  request to play morseCode; sampled only in IDLE.
REQ-007 SHALL have port: morseCode  input  10  five 2-bit symbols, MSB first; 10 = dot, 11 = dash, 00/01 = terminator.
REQ-008 SHALL have port: lampOut  output  1  high while a dot or dash is sounding.
REQ-009 SHALL have port: busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when playback completes.

Function
REQ-011 SHALL implement the states IDLE, FETCH, ON, GAP and FINISH; lampOut = (state==ON), busy = (state!=IDLE), done = (state==FINISH).
REQ-012 In IDLE, start=1 SHALL latch morseCode into a 10-bit shift register, clear the symbol count to 0 and go to FETCH on the next cycle.
REQ-013 FETCH SHALL inspect the shift register's top 2 bits: 10 -> ON for UNIT_CYCLES cycles; 11 -> ON for DASH_UNITS*UNIT_CYCLES cycles; 00/01 -> FINISH.
REQ-014 ON SHALL last exactly the loaded cycle count, then go to GAP.
REQ-015 GAP SHALL last GAP_UNITS*UNIT_CYCLES cycles, then shift left by 2 (zero fill) and increment the symbol count.
REQ-016 At the end of GAP, the block SHALL go to FINISH if the count is 5, otherwise to FETCH.
REQ-017 FINISH SHALL last one cycle, then go to IDLE.
REQ-018 start SHALL be ignored while busy=1, including during FINISH; the latched code is immune to later morseCode changes.
REQ-019 The duration counter SHALL be 26 bits wide, load (duration-1) and count down to 0; overflow is impossible for legal parameters.
REQ-020 Parameters with DASH_UNITS*UNIT_CYCLES >= 2^26 SHALL be illegal (elaboration assertion).

Reset
REQ-021 reset=0 at a clock edge SHALL force IDLE, shift register 0, symbol count 0 and counter 0, so lampOut/busy/done = 0 next cycle.
REQ-022 Reset mid-playback SHALL abandon the code with no done pulse; start is honoured from the first cycle after reset deasserts.

Configuration
REQ-023 When macro MORSE_PLAYER_ABORT_EN is defined, an extra input port abort (1 bit) SHALL exist.
REQ-024 With MORSE_PLAYER_ABORT_EN, abort=1 in any non-IDLE state SHALL force IDLE next cycle, with lampOut low and no done pulse; abort has priority over every other transition, and abort in IDLE has no effect.
REQ-025 Without MORSE_PLAYER_ABORT_EN, the abort port SHALL be absent and behaviour is exactly REQ-011..REQ-022.

Structure
REQ-026 Shared package morse_pkg SHALL hold: SYM_DOT=2'b10, SYM_DASH=2'b11, SYM_END=2'b00, the 10-bit code width, the symbol count 5, and the player state encodings.
REQ-027 The duration down-counter SHALL be a sub-module, morse_unit_timer, with load/value/expired signals; the FSM and shift register stay in morse_player.

Verification (UNIT_CYCLES=4, DASH_UNITS=3, GAP_UNITS=1; start pulse at cycle 0)
REQ-028 Code 10'b1000000000 ("e") SHALL give lampOut high on cycles 2-5, done on cycle 11, and busy on cycles 1-11.
REQ-029 Code 10'b1100000000 ("t") SHALL give lampOut high on cycles 2-13 and done on cycle 19.
REQ-030 Code 10'b1111111111 ("0") SHALL give five 12-cycle lamp pulses starting on cycles 2, 19, 36, 53 and 70, done on cycle 86, and no FETCH after the fifth GAP.
REQ-031 Code 10'b0000000000 SHALL keep lampOut low throughout and give done on cycle 2.
REQ-032 Code "e", with start re-pulsed on cycle 5 and morseCode changed to all-ones on cycle 3, SHALL play unchanged with a single done; reset=0 on cycle 3 of a "t" playback SHALL give lampOut=0 and busy=0 from cycle 4 with no done.
REQ-033 With MORSE_PLAYER_ABORT_EN, abort on cycle 20 of a "0" playback SHALL give lampOut=0 and busy=0 from cycle 21 with no done, and a start on cycle 22 SHALL replay normally.
